exu_issue: RTL and testbench
============================

// Module: exu_issue
// PURPOSE
//  ID->EX issue stage directly upstream of the ALU.
//  - Accepts decoded instructions over a valid/ready handshake.
//  - Selects ALU operands A/B and registers them with the op and writeback tag.
//  - Presents them to the ALU through a 2-entry skid buffer: full throughput, registered in_ready.
// PARAMETERS
//  WIDTH  32  datapath width (pc, operands, imm)
//  OP_W   4   width of ALU opcode field (passed through unchanged)
// PORTS
//  clk          in   1      clock; all state updates on posedge
//  rst          in   1      synchronous reset, active-high
//  in_valid     in   1      upstream instruction valid
//  in_ready     out  1      stage can accept (registered)
//  in_pc        in   WIDTH  instruction pc
//  in_rs1_data  in   WIDTH  rs1 read data
//  in_rs2_data  in   WIDTH  rs2 read data
//  in_imm       in   WIDTH  sign-extended immediate
//  in_a_sel     in   1      A source: 0 rs1, 1 pc
//  in_b_sel     in   2      B source: 00 rs2, 01 imm, 10 const 4, 11 zero
//  in_alu_op    in   OP_W   ALU opcode
//  in_rd        in   5      destination register index
//  in_rd_wen    in   1      destination write enable
//  flush        in   1      kill all buffered entries (redirect)
//  out_valid    out  1      entry valid toward ALU
//  out_ready    in   1      ALU/downstream accepts
//  out_a/out_b  out  WIDTH  selected operands
//  out_alu_op   out  OP_W   opcode
//  out_pc       out  WIDTH  pc of issued entry
//  out_rd       out  5      rd index
//  out_rd_wen   out  1      rd write enable (0 when rd==x0)
//  [EXU_BYPASS_EN only] in_rs1_idx/in_rs2_idx in 5; byp_valid in 1; byp_rd in 5; byp_data in WIDTH
// BEHAVIOUR
//  - Operand selection happens at capture; entries store the selected A/B, never raw rs data.
//  - Capture rules:
//    - out_rd_wen = in_rd_wen & (in_rd!=0).
//    - Const 4 is WIDTH-wide 4; zero is all-0.
//  - Handshake:
//    - Input fire = in_valid & in_ready.
//    - Output fire = out_valid & out_ready.
//    - Payload stable while out_valid & !out_ready.
//  - Entries: MAIN (drives out_*) and SKID. FSM state = {EMPTY, ONE, TWO}.
//  - in_ready = (state!=TWO), registered from next-state; out_valid = (state!=EMPTY).
//  - Transitions:
//    - EMPTY: in fire -> ONE (load MAIN).
//    - ONE:
//      - in & out fire -> ONE (MAIN reloaded).
//      - in fire only -> TWO (load SKID).
//      - out fire only -> EMPTY.
//    - TWO: out fire -> ONE (SKID moves to MAIN). in_ready=0, so no capture.
//  - Latency 1 cycle (fire in cycle N -> out_valid in N+1); throughput 1/cycle; order preserved.
//  - flush:
//    - Next state EMPTY; in_ready=1 the following cycle.
//    - A same-cycle input fire is dropped.
//    - A same-cycle output fire is still counted as taken by the ALU.
//  - Reset:
//    - State EMPTY; out_valid=0; all out_* data=0.
//    - in_ready=0 during rst, 1 from the first cycle after rst deasserts.
//    - rst mid-transfer discards both entries; rst has priority over flush and fires.
// CONFIGURATION
//  - EXU_BYPASS_EN defined:
//    - Adds the bypass ports.
//    - At capture, if byp_valid & byp_rd==in_rsN_idx & in_rsN_idx!=0, byp_data replaces in_rsN_data.
//    - Applies only where that rs is the selected source (A when a_sel=0; B when b_sel=00).
//  - EXU_BYPASS_EN undefined: bypass ports absent; raw rs data used; timing otherwise identical.
// TESTING
//  - Reset:
//    - Stimulus: rst=1 for 2 cycles with in_valid=1.
//    - Required: out_valid=0, in_ready=0, out_a=0. Cycle after release: in_ready=1, state EMPTY.
//  - Operand select:
//    - Stimulus: pc=0x80000010, rs1=5, imm=-3, a_sel=1, b_sel=01.
//    - Required: next cycle out_a=0x80000010, out_b=0xFFFFFFFD.
//    - Stimulus: b_sel=10. Required: out_b=4.
//  - Backpressure:
//    - Stimulus: out_ready=0, issue 3 back-to-back entries.
//    - Required: first two captured, in_ready=0 from cycle 2, out_* holds entry 1.
//    - Stimulus: out_ready=1. Required: entries 1,2 emerge in order, one per cycle.
//  - Flush:
//    - Stimulus: state TWO, flush=1 with in_valid=1.
//    - Required: next cycle out_valid=0, in_ready=1, incoming entry lost.
//  - x0 write:
//    - Stimulus: in_rd=0, in_rd_wen=1. Required: out_rd_wen=0.
//    - Stimulus: in_rd=7. Required: out_rd_wen=1.
//  - Bypass (EXU_BYPASS_EN):
//    - Stimulus: rs1_idx=3, byp_valid=1, byp_rd=3, byp_data=0x1234.
//    - Required: out_a=0x1234.
//    - Stimulus: same bypass with rs1_idx=0. Required: raw data used.

Source files
------------

// File: rtl/exu_issue.sv
// ID->EX issue stage: selects ALU operands at capture and presents them through a 2-entry skid buffer.
// Optional operand bypass from a late writeback is enabled by defining EXU_BYPASS_EN.
module exu_issue #(
    parameter int WIDTH = 32,
    parameter int OP_W  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_pc,
    input  logic [WIDTH-1:0] in_rs1_data,
    input  logic [WIDTH-1:0] in_rs2_data,
    input  logic [WIDTH-1:0] in_imm,
    input  logic             in_a_sel,
    input  logic [1:0]       in_b_sel,
    input  logic [OP_W-1:0]  in_alu_op,
    input  logic [4:0]       in_rd,
    input  logic             in_rd_wen,
`ifdef EXU_BYPASS_EN
    input  logic [4:0]       in_rs1_idx,
    input  logic [4:0]       in_rs2_idx,
    input  logic             byp_valid,
    input  logic [4:0]       byp_rd,
    input  logic [WIDTH-1:0] byp_data,
`endif
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_a,
    output logic [WIDTH-1:0] out_b,
    output logic [OP_W-1:0]  out_alu_op,
    output logic [WIDTH-1:0] out_pc,
    output logic [4:0]       out_rd,
    output logic             out_rd_wen
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [OP_W-1:0]  op;
        logic [WIDTH-1:0] pc;
        logic [4:0]       rd;
        logic             wen;
    } entry_t;

    state_t           state;
    state_t           state_nx;
    entry_t           main_q;
    entry_t           skid_q;
    entry_t           cap;
    logic             in_ready_q;
    logic             in_fire;
    logic             out_fire;
    logic             load_main;
    logic             load_skid;
    logic             skid_to_main;
    logic [WIDTH-1:0] rs1_eff;
    logic [WIDTH-1:0] rs2_eff;

`ifdef EXU_BYPASS_EN
    assign rs1_eff = (byp_valid && (byp_rd == in_rs1_idx) && (in_rs1_idx != 5'd0)) ? byp_data : in_rs1_data;
    assign rs2_eff = (byp_valid && (byp_rd == in_rs2_idx) && (in_rs2_idx != 5'd0)) ? byp_data : in_rs2_data;
`else
    assign rs1_eff = in_rs1_data;
    assign rs2_eff = in_rs2_data;
`endif

    // The ready register is preset during reset; gating by rst keeps the port low while reset is held.
    assign in_ready   = in_ready_q & ~rst;
    assign out_valid  = (state != EMPTY);
    assign in_fire    = in_valid & in_ready;
    assign out_fire   = out_valid & out_ready;

    assign out_a      = main_q.a;
    assign out_b      = main_q.b;
    assign out_alu_op = main_q.op;
    assign out_pc     = main_q.pc;
    assign out_rd     = main_q.rd;
    assign out_rd_wen = main_q.wen;

    // Operand selection and rd-enable qualification of the incoming instruction.
    always_comb begin
        cap    = '0;
        cap.a  = in_a_sel ? in_pc : rs1_eff;
        case (in_b_sel)
            2'b00:   cap.b = rs2_eff;
            2'b01:   cap.b = in_imm;
            2'b10:   cap.b = WIDTH'(32'd4);
            2'b11:   cap.b = '0;
            default: cap.b = '0;
        endcase
        cap.op  = in_alu_op;
        cap.pc  = in_pc;
        cap.rd  = in_rd;
        cap.wen = in_rd_wen & (in_rd != 5'd0);
    end

    // Next-state and entry-move decisions for the skid buffer.
    always_comb begin
        state_nx     = state;
        load_main    = 1'b0;
        load_skid    = 1'b0;
        skid_to_main = 1'b0;
        if (flush) begin
            state_nx = EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (in_fire) begin
                        state_nx  = ONE;
                        load_main = 1'b1;
                    end else begin
                        state_nx  = EMPTY;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        load_main = 1'b1;
                    end else if (in_fire) begin
                        state_nx  = TWO;
                        load_skid = 1'b1;
                    end else if (out_fire) begin
                        state_nx  = EMPTY;
                    end else begin
                        state_nx  = ONE;
                    end
                end
                TWO: begin
                    if (out_fire) begin
                        state_nx     = ONE;
                        skid_to_main = 1'b1;
                    end else begin
                        state_nx     = TWO;
                    end
                end
                default: state_nx = EMPTY;
            endcase
        end
    end

    // State, registered ready and entry storage.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= EMPTY;
            in_ready_q <= 1'b1;
            main_q     <= '0;
            skid_q     <= '0;
        end else begin
            state      <= state_nx;
            in_ready_q <= (state_nx != TWO);
            if (load_main) begin
                main_q <= cap;
            end else if (skid_to_main) begin
                main_q <= skid_q;
            end
            if (load_skid) begin
                skid_q <= cap;
            end
        end
    end

endmodule

// File: tb/tb_exu_issue.sv
// Self-checking bench for exu_issue: directed vector table, hand-written corner sequences,
// and randomized traffic against a queue-based reference model.
module tb_exu_issue;

    localparam int WIDTH = 32;
    localparam int OP_W  = 4;
    localparam int PW    = 3 * WIDTH + OP_W + 6;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_pc, in_rs1_data, in_rs2_data, in_imm;
    logic             in_a_sel;
    logic [1:0]       in_b_sel;
    logic [OP_W-1:0]  in_alu_op;
    logic [4:0]       in_rd;
    logic             in_rd_wen;
`ifdef EXU_BYPASS_EN
    logic [4:0]       in_rs1_idx, in_rs2_idx, byp_rd;
    logic             byp_valid;
    logic [WIDTH-1:0] byp_data;
`endif
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_a, out_b, out_pc;
    logic [OP_W-1:0]  out_alu_op;
    logic [4:0]       out_rd;
    logic             out_rd_wen;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    exu_issue #(.WIDTH(WIDTH), .OP_W(OP_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data), .in_imm(in_imm),
        .in_a_sel(in_a_sel), .in_b_sel(in_b_sel), .in_alu_op(in_alu_op),
        .in_rd(in_rd), .in_rd_wen(in_rd_wen),
`ifdef EXU_BYPASS_EN
        .in_rs1_idx(in_rs1_idx), .in_rs2_idx(in_rs2_idx),
        .byp_valid(byp_valid), .byp_rd(byp_rd), .byp_data(byp_data),
`endif
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .out_a(out_a), .out_b(out_b), .out_alu_op(out_alu_op), .out_pc(out_pc),
        .out_rd(out_rd), .out_rd_wen(out_rd_wen)
    );

    typedef struct {
        logic [WIDTH-1:0] pc, rs1, rs2, imm;
        logic             a_sel;
        logic [1:0]       b_sel;
        logic [4:0]       rd;
        logic             wen;
        logic [WIDTH-1:0] exp_a, exp_b;
        logic             exp_wen;
    } vec_t;

    vec_t vecs[7];
    logic [PW-1:0] model_q[$];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [WIDTH-1:0] pc, rs1, rs2, imm, input logic a_sel,
                         input logic [1:0] b_sel, input logic [OP_W-1:0] op,
                         input logic [4:0] rd, input logic wen);
        in_pc = pc; in_rs1_data = rs1; in_rs2_data = rs2; in_imm = imm;
        in_a_sel = a_sel; in_b_sel = b_sel; in_alu_op = op; in_rd = rd; in_rd_wen = wen;
    endtask

    // Reference: what an accepted instruction should look like at the ALU, from the selection rules.
    function automatic logic [PW-1:0] ref_entry(input logic [WIDTH-1:0] pc, rs1, rs2, imm,
                                                input logic a_sel, input logic [1:0] b_sel,
                                                input logic [OP_W-1:0] op, input logic [4:0] rd,
                                                input logic wen);
        logic [WIDTH-1:0] a, b;
        a = a_sel ? pc : rs1;
        if (b_sel == 2'd0)      b = rs2;
        else if (b_sel == 2'd1) b = imm;
        else if (b_sel == 2'd2) b = 32'd4;
        else                    b = 32'd0;
        return {a, b, op, pc, rd, (wen && rd != 5'd0)};
    endfunction

    function automatic logic [PW-1:0] dut_entry();
        return {out_a, out_b, out_alu_op, out_pc, out_rd, out_rd_wen};
    endfunction

    initial begin
        vecs[0] = '{32'h80000010, 32'd5, 32'd9, 32'hFFFFFFFD, 1'b1, 2'b01, 5'd1, 1'b1, 32'h80000010, 32'hFFFFFFFD, 1'b1};
        vecs[1] = '{32'h80000010, 32'd5, 32'd9, 32'hFFFFFFFD, 1'b1, 2'b10, 5'd2, 1'b1, 32'h80000010, 32'd4, 1'b1};
        vecs[2] = '{32'h00001000, 32'h11, 32'h22, 32'h33, 1'b0, 2'b00, 5'd3, 1'b1, 32'h11, 32'h22, 1'b1};
        vecs[3] = '{32'h00001004, 32'h44, 32'h55, 32'h66, 1'b0, 2'b11, 5'd4, 1'b1, 32'h44, 32'd0, 1'b1};
        vecs[4] = '{32'h00001008, 32'h1, 32'h2, 32'h3, 1'b0, 2'b01, 5'd0, 1'b1, 32'h1, 32'h3, 1'b0};
        vecs[5] = '{32'h0000100C, 32'h7, 32'h8, 32'h9, 1'b0, 2'b00, 5'd7, 1'b1, 32'h7, 32'h8, 1'b1};
        vecs[6] = '{32'h00001010, 32'hA, 32'hB, 32'hC, 1'b1, 2'b00, 5'd7, 1'b0, 32'h1010, 32'hB, 1'b0};

        rst = 1'b1; in_valid = 1'b1; flush = 1'b0; out_ready = 1'b1;
        drive(32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 2'b00, 4'd0, 5'd0, 1'b0);
`ifdef EXU_BYPASS_EN
        in_rs1_idx = 5'd0; in_rs2_idx = 5'd0; byp_valid = 1'b0; byp_rd = 5'd0; byp_data = '0;
`endif
        // Reset held two cycles with in_valid asserted.
        tick();
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_out_a", out_a, 32'd0);
        tick();
        chk("rst2_in_ready", in_ready, 1'b0);
        rst = 1'b0; in_valid = 1'b0;
        #1;
        chk("post_rst_in_ready", in_ready, 1'b1);
        chk("post_rst_out_valid", out_valid, 1'b0);

        // Directed table: back-to-back with out_ready=1, each entry visible one cycle later.
        for (int i = 0; i < 7; i++) begin
            drive(vecs[i].pc, vecs[i].rs1, vecs[i].rs2, vecs[i].imm, vecs[i].a_sel, vecs[i].b_sel,
                  OP_W'(i), vecs[i].rd, vecs[i].wen);
            in_valid = 1'b1;
            tick();
            chk($sformatf("vec%0d_valid", i), out_valid, 1'b1);
            chk($sformatf("vec%0d_a", i), out_a, vecs[i].exp_a);
            chk($sformatf("vec%0d_b", i), out_b, vecs[i].exp_b);
            chk($sformatf("vec%0d_wen", i), out_rd_wen, vecs[i].exp_wen);
            chk($sformatf("vec%0d_pc", i), out_pc, vecs[i].pc);
        end
        in_valid = 1'b0;
        tick();
        chk("drain_out_valid", out_valid, 1'b0);

        // Backpressure: three back-to-back offers, only two accepted.
        out_ready = 1'b0; in_valid = 1'b1;
        drive(32'h100, 32'hE1, 32'h0, 32'h0, 1'b0, 2'b11, 4'd1, 5'd1, 1'b1);
        tick();
        chk("bp1_in_ready", in_ready, 1'b1);
        chk("bp1_out_a", out_a, 32'hE1);
        drive(32'h104, 32'hE2, 32'h0, 32'h0, 1'b0, 2'b11, 4'd2, 5'd2, 1'b1);
        tick();
        chk("bp2_in_ready", in_ready, 1'b0);
        chk("bp2_out_a", out_a, 32'hE1);
        drive(32'h108, 32'hE3, 32'h0, 32'h0, 1'b0, 2'b11, 4'd3, 5'd3, 1'b1);
        tick();
        chk("bp3_in_ready", in_ready, 1'b0);
        chk("bp3_out_a_hold", out_a, 32'hE1);
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
        chk("bp_drain1_valid", out_valid, 1'b1);
        chk("bp_drain1_a", out_a, 32'hE2);
        chk("bp_drain1_in_ready", in_ready, 1'b1);
        tick();
        chk("bp_drain2_valid", out_valid, 1'b0);

        // Flush from TWO with a simultaneous offer: everything is dropped.
        out_ready = 1'b0; in_valid = 1'b1;
        drive(32'h200, 32'hF1, 32'h0, 32'h0, 1'b0, 2'b11, 4'd1, 5'd1, 1'b1);
        tick();
        drive(32'h204, 32'hF2, 32'h0, 32'h0, 1'b0, 2'b11, 4'd2, 5'd2, 1'b1);
        tick();
        chk("pre_flush_in_ready", in_ready, 1'b0);
        flush = 1'b1;
        tick();
        chk("flush_out_valid", out_valid, 1'b0);
        chk("flush_in_ready", in_ready, 1'b1);
        flush = 1'b0; in_valid = 1'b0;
        tick();
        chk("flush_lost", out_valid, 1'b0);

`ifdef EXU_BYPASS_EN
        out_ready = 1'b1; in_valid = 1'b1;
        drive(32'h300, 32'h5555, 32'h0, 32'h0, 1'b0, 2'b11, 4'd0, 5'd1, 1'b1);
        in_rs1_idx = 5'd3; byp_valid = 1'b1; byp_rd = 5'd3; byp_data = 32'h1234;
        tick();
        chk("byp_a", out_a, 32'h1234);
        in_rs1_idx = 5'd0; byp_rd = 5'd0;
        tick();
        chk("byp_x0_raw", out_a, 32'h5555);
        in_valid = 1'b0; byp_valid = 1'b0;
        tick();
`endif

        // Randomized traffic against the in-order queue model (capacity 2).
        model_q.delete();
        for (int i = 0; i < 600; i++) begin
            logic fin, fout;
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 19) == 0);
            drive($urandom, $urandom, $urandom, $urandom, 1'($urandom_range(0, 1)),
                  2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
                  5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
            #1;
            chk("rnd_out_valid", out_valid, model_q.size() > 0);
            chk("rnd_in_ready", in_ready, model_q.size() < 2);
            if (model_q.size() > 0) chk("rnd_payload", dut_entry(), model_q[0]);
            fin  = in_valid && (model_q.size() < 2);
            fout = out_ready && (model_q.size() > 0);
            if (fout) void'(model_q.pop_front());
            if (flush) model_q.delete();
            else if (fin) model_q.push_back(ref_entry(in_pc, in_rs1_data, in_rs2_data, in_imm,
                                                      in_a_sel, in_b_sel, in_alu_op, in_rd, in_rd_wen));
            @(posedge clk);
            #1;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
